board_io: RTL

BOARD_IO -- requirements
Module: board_io

---
 rtl/board_io_pkg.sv | 17 +
 rtl/btn_debounce.sv | 73 +++++++
 rtl/board_io.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg
// Shared constants for the board_io register block: the byte offsets of the
// five bus-visible registers and the width of the optional PWM counter.
// Imported by board_io and btn_debounce.
// ---------------------------------------------------------------------------
package board_io_pkg;

   localparam logic [4:0] ADDR_LED_OUT   = 5'h00;
   localparam logic [4:0] ADDR_BTN_STATE = 5'h04;
   localparam logic [4:0] ADDR_BTN_EVENT = 5'h08;
   localparam logic [4:0] ADDR_IRQ_MASK  = 5'h0C;
   localparam logic [4:0] ADDR_PWM_DUTY  = 5'h10;

   localparam int PWM_CNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One push-button channel: a 2-FF synchronizer followed by a stability
// counter.  The accepted state only flips after the synchronized level has
// differed from it for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   btn_i    : raw asynchronous button level (1 = pressed)
//   state_o  : debounced (accepted) level
//   rise_o   : one-clock pulse, high in the cycle whose edge accepts a press
// ---------------------------------------------------------------------------
module btn_debounce
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic state_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             state_q;
   logic             state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;

   // Synchronizer, accepted state and stability counter.  A reset in the
   // middle of a debounce throws the partial count away.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter only runs while the synchronized level disagrees with the
   // accepted state; any agreement snaps it back to zero.  The clock that
   // finds the counter at its last value is the one that flips the state.
   always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      accept  = 1'b0;
      if (sync2_q != state_q) begin
         if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign state_o = state_q;
   assign rise_o  = accept & sync2_q;

endmodule

// File: rtl/board_io.sv
// ---------------------------------------------------------------------------
// board_io
// Small board peripheral: debounced push-buttons with sticky press events
// and a maskable level interrupt, an LED output register and, optionally,
// a global PWM brightness control for the LEDs.
//
// Build option
//   BOARD_IO_PWM_EN : when defined, a free-running 8-bit counter gates the
//                     LEDs against PWM_DUTY (0xFF = always on).  When not
//                     defined, PWM_DUTY reads 0 and no counter exists.
//
// Ports
//   sys_clk, sys_rst_n   : clock, asynchronous active-low reset
//   button_in[NUM_BTN]   : raw button levels, 1 = pressed
//   bus_addr/we/re/wdata : simple register bus, single-cycle strobes
//   bus_rdata            : read data, valid the clock after bus_re, held
//   led[NUM_LED]         : LED pins, polarity set by LED_ACTIVE_LOW
//   irq                  : level interrupt, |(BTN_EVENT & IRQ_MASK), registered
//
// Register map: 0x00 LED_OUT (RW), 0x04 BTN_STATE (RO), 0x08 BTN_EVENT (W1C),
//               0x0C IRQ_MASK (RW), 0x10 PWM_DUTY (RW)
// ---------------------------------------------------------------------------
module board_io
   import board_io_pkg::*;
#(
   parameter int NUM_BTN         = 1,
   parameter int NUM_LED         = 6,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int LED_ACTIVE_LOW  = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [NUM_BTN-1:0] button_in,
   input  logic [4:0]         bus_addr,
   input  logic               bus_we,
   input  logic               bus_re,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        bus_rdata,
   output logic [NUM_LED-1:0] led,
   output logic               irq
);

   localparam logic [NUM_LED-1:0] LED_OFF = {NUM_LED{LED_ACTIVE_LOW != 0}};

   logic [NUM_BTN-1:0] btnState;
   logic [NUM_BTN-1:0] btnRise;
   logic [NUM_LED-1:0] ledOut_q,   ledOut_d;
   logic [NUM_BTN-1:0] btnEvent_q, btnEvent_d;
   logic [NUM_BTN-1:0] irqMask_q,  irqMask_d;
   logic [31:0]        rdata_q,    rdata_d;
   logic               irq_q,      irq_d;
   logic [NUM_LED-1:0] led_q,      led_d;
   logic [NUM_LED-1:0] lit;
   logic               unusedWdata;

   // Upper write-data bits are meaningless for the narrow registers.
   assign unusedWdata = ^bus_wdata;

   // One synchronizer/debouncer per button.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i  (sys_clk),
         .rst_ni (sys_rst_n),
         .btn_i  (button_in[i]),
         .state_o(btnState[i]),
         .rise_o (btnRise[i])
      );
   end

`ifdef BOARD_IO_PWM_EN
   logic [PWM_CNT_W-1:0] pwmDuty_q, pwmDuty_d;
   logic [PWM_CNT_W-1:0] pwmCnt_q;
   logic                 pwmOn;

   // Duty register resets to full brightness; the counter just wraps.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pwmDuty_q <= '1;
         pwmCnt_q  <= '0;
      end else begin
         pwmDuty_q <= pwmDuty_d;
         pwmCnt_q  <= pwmCnt_q + PWM_CNT_W'(1);
      end
   end

   // A duty of all-ones means "never off", which the plain compare cannot
   // express because the counter reaches 0xFF for one clock per period.
   always_comb begin
      pwmDuty_d = pwmDuty_q;
      if (bus_we && (bus_addr == ADDR_PWM_DUTY)) begin
         pwmDuty_d = bus_wdata[PWM_CNT_W-1:0];
      end
      pwmOn = (pwmCnt_q < pwmDuty_q) || (pwmDuty_q == {PWM_CNT_W{1'b1}});
      lit   = ledOut_q & {NUM_LED{pwmOn}};
   end
`else
   assign lit = ledOut_q;
`endif

   // Register writes.  A press accepted on the same clock as a W1C of the
   // same event bit wins, so the OR of the new rises comes after the clear.
   always_comb begin
      ledOut_d   = ledOut_q;
      irqMask_d  = irqMask_q;
      btnEvent_d = btnEvent_q;
      if (bus_we && (bus_addr == ADDR_LED_OUT)) begin
         ledOut_d = bus_wdata[NUM_LED-1:0];
      end
      if (bus_we && (bus_addr == ADDR_IRQ_MASK)) begin
         irqMask_d = bus_wdata[NUM_BTN-1:0];
      end
      if (bus_we && (bus_addr == ADDR_BTN_EVENT)) begin
         btnEvent_d = btnEvent_q & ~bus_wdata[NUM_BTN-1:0];
      end
      btnEvent_d = btnEvent_d | btnRise;
   end

   // Read mux samples the current register contents, so a read colliding
   // with a write to the same address returns the pre-write value.  The
   // result is held until the next read strobe.
   always_comb begin
      rdata_d = rdata_q;
      if (bus_re) begin
         case (bus_addr)
            ADDR_LED_OUT:   rdata_d = 32'(ledOut_q);
            ADDR_BTN_STATE: rdata_d = 32'(btnState);
            ADDR_BTN_EVENT: rdata_d = 32'(btnEvent_q);
            ADDR_IRQ_MASK:  rdata_d = 32'(irqMask_q);
`ifdef BOARD_IO_PWM_EN
            ADDR_PWM_DUTY:  rdata_d = 32'(pwmDuty_q);
`endif
            default:        rdata_d = '0;
         endcase
      end
      irq_d = |(btnEvent_q & irqMask_q);
      led_d = lit ^ LED_OFF;
   end

   // All bus-visible state and the registered outputs.  LEDs come out of
   // reset at the unlit pin level rather than all-zero.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ledOut_q   <= '0;
         irqMask_q  <= '0;
         btnEvent_q <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         led_q      <= LED_OFF;
      end else begin
         ledOut_q   <= ledOut_d;
         irqMask_q  <= irqMask_d;
         btnEvent_q <= btnEvent_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         led_q      <= led_d;
      end
   end

   assign bus_rdata = rdata_q;
   assign irq       = irq_q;
   assign led       = led_q;

endmodule
